mem_stage_lsu: RTL and testbench

- MEM pipeline stage: load/store unit plus the MEM/WB pipeline register.
- Consumes EX/MEM register outputs and drives a valid/ack data-memory port.
- Extends load data, stalls the pipe while a memory access is outstanding, and registers results into the MEM/WB register feeding the write-back datapath.

---
 rtl/mem_stage_lsu.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit driving a valid/ack data-memory port,
// load-data extension, pipe stall while an access is outstanding, and the
// MEM/WB pipeline register feeding write-back.
module mem_stage_lsu #(
  parameter int          INST_WIDTH          = 32,
  parameter int          DATA_WIDTH          = 32,
  parameter int          DATA_ADDR_WIDTH     = 32,
  parameter int          REGISTER_ADDR_WIDTH = 5,
  parameter logic [31:0] NOP_INST            = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INST_WIDTH-1:0]          INST_EX_MEM_o,
  input  logic                           reg_write_EX_MEM_o,
  input  logic [1:0]                     result_sel_EX_MEM_o,
  input  logic                           mem_read_EX_MEM_o,
  input  logic                           mem_write_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]          write_data_EX_MEM_o,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
  input  logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DATA_ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]          dmem_wdata,
  output logic [3:0]                     dmem_wstrb,
  input  logic                           dmem_ack,
  input  logic [DATA_WIDTH-1:0]          dmem_rdata,
  output logic                           stall_MEM,
  output logic                           misalign_MEM,
  output logic [INST_WIDTH-1:0]          INST_MEM_WB_o,
  output logic                           reg_write_MEM_WB_o,
  output logic [1:0]                     result_sel_MEM_WB_o,
  output logic [DATA_WIDTH-1:0]          alu_res_MEM_WB_o,
  output logic [DATA_WIDTH-1:0]          data_mem_rdata_MEM_WB_o,
  output logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB_o,
  output logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_MEM_WB_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [2:0] funct3_s;
  logic [1:0] off_s;
  logic       mem_op_s;
  logic       misalign_raw_s;
  logic       misalign_s;
  logic       aligned_op_s;
  logic       req_s;
  logic       ack_s;

  logic [INST_WIDTH-1:0]          inst_d;
  logic                           reg_write_d;
  logic [1:0]                     result_sel_d;
  logic [DATA_WIDTH-1:0]          alu_res_d;
  logic [DATA_WIDTH-1:0]          rdata_d;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_d;
  logic [DATA_ADDR_WIDTH-1:0]     pc4_d;

  logic [INST_WIDTH-1:0]          inst_q;
  logic                           reg_write_q;
  logic [1:0]                     result_sel_q;
  logic [DATA_WIDTH-1:0]          alu_res_q;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_ADDR_WIDTH-1:0]     pc4_q;

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  assign funct3_s     = INST_EX_MEM_o[14:12];
  assign off_s        = alu_res_EX_MEM_o[1:0];
  assign mem_op_s     = mem_read_EX_MEM_o | mem_write_EX_MEM_o;
  assign misalign_s   = mem_op_s & misalign_raw_s;
  assign aligned_op_s = mem_op_s & ~misalign_raw_s;

  // Detect halfword/word accesses that do not sit on their natural boundary.
  always_comb begin
    misalign_raw_s = 1'b0;
    case (funct3_s[1:0])
      2'b01:   misalign_raw_s = off_s[0];
      2'b10:   misalign_raw_s = (off_s != 2'b00);
      default: misalign_raw_s = 1'b0;
    endcase
  end

  // Request FSM: issue combinationally from IDLE, hold the request in BUSY until ack.
  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_op_s) begin
          req_s = 1'b1;
          if (dmem_ack) begin
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        req_s = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset drops the request at once, abandoning any access in flight.
  assign dmem_req     = req_s & ~rst;
  assign ack_s        = dmem_ack & dmem_req;
  assign stall_MEM    = dmem_req & ~dmem_ack;
  assign misalign_MEM = misalign_s & ~rst;
  assign dmem_we      = mem_write_EX_MEM_o;
  assign dmem_addr    = {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};

  // Store lane strobes and replicated store data by access size.
  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = write_data_EX_MEM_o;
    case (funct3_s[1:0])
      2'b00: begin
        dmem_wdata = {4{write_data_EX_MEM_o[7:0]}};
        if (mem_write_EX_MEM_o) begin
          dmem_wstrb = 4'b0001 << off_s;
        end else begin
          dmem_wstrb = 4'b0000;
        end
      end
      2'b01: begin
        dmem_wdata = {2{write_data_EX_MEM_o[15:0]}};
        if (mem_write_EX_MEM_o) begin
          dmem_wstrb = 4'b0011 << off_s;
        end else begin
          dmem_wstrb = 4'b0000;
        end
      end
      default: begin
        dmem_wdata = write_data_EX_MEM_o;
        if (mem_write_EX_MEM_o) begin
          dmem_wstrb = 4'b1111;
        end else begin
          dmem_wstrb = 4'b0000;
        end
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, else pass the instruction through.
  always_comb begin
    inst_d       = NOP_INST[INST_WIDTH-1:0];
    reg_write_d  = 1'b0;
    result_sel_d = 2'b00;
    alu_res_d    = {DATA_WIDTH{1'b0}};
    rdata_d      = {DATA_WIDTH{1'b0}};
    rd_d         = {REGISTER_ADDR_WIDTH{1'b0}};
    pc4_d        = {DATA_ADDR_WIDTH{1'b0}};
    if (stall_MEM) begin
      inst_d = NOP_INST[INST_WIDTH-1:0];
    end else begin
      inst_d       = INST_EX_MEM_o;
      reg_write_d  = reg_write_EX_MEM_o & ~misalign_s;
      result_sel_d = result_sel_EX_MEM_o;
      alu_res_d    = alu_res_EX_MEM_o;
      rd_d         = rd_EX_MEM_o;
      pc4_d        = PC_plus_4_EX_MEM_o;
      if (mem_read_EX_MEM_o && ack_s) begin
        rdata_d = load_extend(dmem_rdata, funct3_s, off_s);
      end else begin
        rdata_d = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q       <= NOP_INST[INST_WIDTH-1:0];
      reg_write_q  <= 1'b0;
      result_sel_q <= 2'b00;
      alu_res_q    <= {DATA_WIDTH{1'b0}};
      rdata_q      <= {DATA_WIDTH{1'b0}};
      rd_q         <= {REGISTER_ADDR_WIDTH{1'b0}};
      pc4_q        <= {DATA_ADDR_WIDTH{1'b0}};
    end else begin
      inst_q       <= inst_d;
      reg_write_q  <= reg_write_d;
      result_sel_q <= result_sel_d;
      alu_res_q    <= alu_res_d;
      rdata_q      <= rdata_d;
      rd_q         <= rd_d;
      pc4_q        <= pc4_d;
    end
  end

  assign INST_MEM_WB_o           = inst_q;
  assign reg_write_MEM_WB_o      = reg_write_q;
  assign result_sel_MEM_WB_o     = result_sel_q;
  assign alu_res_MEM_WB_o        = alu_res_q;
  assign data_mem_rdata_MEM_WB_o = rdata_q;
  assign rd_MEM_WB_o             = rd_q;
  assign PC_plus_4_MEM_WB_o      = pc4_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        reg_write;
  logic [1:0]  result_sel;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_res;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic [31:0] pc4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_MEM;
  logic        misalign_MEM;
  logic [31:0] inst_wb;
  logic        reg_write_wb;
  logic [1:0]  result_sel_wb;
  logic [31:0] alu_res_wb;
  logic [31:0] rdata_wb;
  logic [4:0]  rd_wb;
  logic [31:0] pc4_wb;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int st_cnt = 0;
  int req_cyc = 0;

  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic [3:0]  snap_wstrb;
  int          hs0, st0, rq0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .INST_EX_MEM_o(inst), .reg_write_EX_MEM_o(reg_write),
    .result_sel_EX_MEM_o(result_sel), .mem_read_EX_MEM_o(mem_read),
    .mem_write_EX_MEM_o(mem_write), .alu_res_EX_MEM_o(alu_res),
    .write_data_EX_MEM_o(write_data), .rd_EX_MEM_o(rd),
    .PC_plus_4_EX_MEM_o(pc4),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_MEM(stall_MEM), .misalign_MEM(misalign_MEM),
    .INST_MEM_WB_o(inst_wb), .reg_write_MEM_WB_o(reg_write_wb),
    .result_sel_MEM_WB_o(result_sel_wb), .alu_res_MEM_WB_o(alu_res_wb),
    .data_mem_rdata_MEM_WB_o(rdata_wb), .rd_MEM_WB_o(rd_wb),
    .PC_plus_4_MEM_WB_o(pc4_wb)
  );

  // Count request cycles, completed handshakes and completed stores.
  always @(posedge clk) begin
    if (!rst && dmem_req) begin
      req_cyc <= req_cyc + 1;
      if (dmem_ack) begin
        hs_cnt <= hs_cnt + 1;
        if (dmem_we) st_cnt <= st_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
    mk_inst = {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic drive(input logic [31:0] i, input logic rw, input logic [1:0] sel,
                       input logic rde, input logic wre, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r);
    inst = i; reg_write = rw; result_sel = sel; mem_read = rde; mem_write = wre;
    alu_res = a; write_data = wd; rd = r; pc4 = a + 32'd4;
  endtask

  // Runs one aligned memory access already driven at this negedge; ack after 'waits' cycles.
  task automatic run_mem(input int waits, input logic [31:0] rdata);
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack   = (i == waits);
      dmem_rdata = (i == waits) ? rdata : 32'h0;
      #1;
      check_eq("req_high", {31'd0, dmem_req}, 32'd1);
      check_eq("stall", {31'd0, stall_MEM}, (i != waits) ? 32'd1 : 32'd0);
      if (i == waits) begin
        snap_addr = dmem_addr; snap_wdata = dmem_wdata; snap_wstrb = dmem_wstrb;
      end
      @(posedge clk); #1;
      if (i != waits) begin
        check_eq("bubble_inst", inst_wb, 32'h00000013);
        check_eq("bubble_rw", {31'd0, reg_write_wb}, 32'd0);
      end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(32'h00000033, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #3;
    check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_inst", inst_wb, 32'h00000013);
    check_eq("rst_rw", {31'd0, reg_write_wb}, 32'd0);
    check_eq("rst_alu", alu_res_wb, 32'd0);
    check_eq("rst_stall", {31'd0, stall_MEM}, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_MEM}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ALU op passes straight through
    @(negedge clk);
    drive(32'h00000033, 1'b1, 2'd0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    #1;
    check_eq("alu_noreq", {31'd0, dmem_req}, 32'd0);
    check_eq("alu_nostall", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    check_eq("alu_rd", {27'd0, rd_wb}, 32'd5);
    check_eq("alu_res", alu_res_wb, 32'h1234);
    check_eq("alu_rw", {31'd0, reg_write_wb}, 32'd1);
    check_eq("alu_inst", inst_wb, 32'h00000033);
    check_eq("alu_pc4", pc4_wb, 32'h1238);

    // LB at 0x103, two wait cycles
    @(negedge clk);
    drive(mk_inst(3'b000, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd7);
    rq0 = req_cyc;
    run_mem(2, 32'h80FF_FF00);
    check_eq("lb_addr", snap_addr, 32'h100);
    check_eq("lb_wstrb", {28'd0, snap_wstrb}, 32'd0);
    check_eq("lb_data", rdata_wb, 32'hFFFF_FF80);
    check_eq("lb_rd", {27'd0, rd_wb}, 32'd7);
    check_eq("lb_rw", {31'd0, reg_write_wb}, 32'd1);
    check_eq("lb_sel", {30'd0, result_sel_wb}, 32'd1);
    check_eq("lb_reqcyc", req_cyc - rq0, 32'd3);

    // LBU same address, two wait cycles
    @(negedge clk);
    drive(mk_inst(3'b100, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd8);
    run_mem(2, 32'h80FF_FF00);
    check_eq("lbu_data", rdata_wb, 32'h0000_0080);

    // LH at 0x102, zero-wait
    @(negedge clk);
    drive(mk_inst(3'b001, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd9);
    run_mem(0, 32'h80FF_FF00);
    check_eq("lh_data", rdata_wb, 32'hFFFF_80FF);

    // SH at 0x202, zero-wait
    @(negedge clk);
    drive(mk_inst(3'b001, 7'h23), 1'b0, 2'd0, 1'b0, 1'b1, 32'h202, 32'h0000_ABCD, 5'd0);
    hs0 = hs_cnt; st0 = st_cnt; rq0 = req_cyc;
    run_mem(0, 32'h0);
    check_eq("sh_addr", snap_addr, 32'h200);
    check_eq("sh_wstrb", {28'd0, snap_wstrb}, 32'hC);
    check_eq("sh_wdata", snap_wdata, 32'hABCD_ABCD);
    check_eq("sh_once", st_cnt - st0, 32'd1);
    check_eq("sh_reqcyc", req_cyc - rq0, 32'd1);
    check_eq("sh_rdata0", rdata_wb, 32'd0);

    // SB at 0x201
    @(negedge clk);
    drive(mk_inst(3'b000, 7'h23), 1'b0, 2'd0, 1'b0, 1'b1, 32'h201, 32'h0000_005A, 5'd0);
    run_mem(0, 32'h0);
    check_eq("sb_wstrb", {28'd0, snap_wstrb}, 32'h2);
    check_eq("sb_wdata", snap_wdata, 32'h5A5A_5A5A);

    // Misaligned LW at 0x101
    @(negedge clk);
    drive(mk_inst(3'b010, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h101, 32'h0, 5'd10);
    dmem_ack = 1'b0;
    #1;
    check_eq("mis_pulse", {31'd0, misalign_MEM}, 32'd1);
    check_eq("mis_noreq", {31'd0, dmem_req}, 32'd0);
    check_eq("mis_nostall", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    check_eq("mis_rw", {31'd0, reg_write_wb}, 32'd0);
    check_eq("mis_inst", inst_wb, mk_inst(3'b010, 7'h03));
    @(negedge clk);
    drive(mk_inst(3'b001, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h203, 32'h0, 5'd11);
    #1;
    check_eq("mis_sh_pulse", {31'd0, misalign_MEM}, 32'd1);
    @(negedge clk);
    drive(32'h00000033, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    #1;
    check_eq("mis_clear", {31'd0, misalign_MEM}, 32'd0);

    // Reset while BUSY
    @(negedge clk);
    drive(mk_inst(3'b010, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd12);
    dmem_ack = 1'b0;
    #1;
    check_eq("busy_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    check_eq("busy_hold", {31'd0, dmem_req}, 32'd1);
    check_eq("busy_stall", {31'd0, stall_MEM}, 32'd1);
    #1; rst = 1'b1; #1;
    check_eq("rstb_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rstb_inst", inst_wb, 32'h00000013);
    check_eq("rstb_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_mem(1, 32'h1122_3344);
    check_eq("post_rst_data", rdata_wb, 32'h1122_3344);
    check_eq("post_rst_rd", {27'd0, rd_wb}, 32'd12);

    // Back-to-back SW then LW, one wait cycle each
    hs0 = hs_cnt; st0 = st_cnt;
    @(negedge clk);
    drive(mk_inst(3'b010, 7'h23), 1'b0, 2'd0, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 5'd0);
    run_mem(1, 32'h0);
    check_eq("sw_addr", snap_addr, 32'h400);
    check_eq("sw_wstrb", {28'd0, snap_wstrb}, 32'hF);
    check_eq("sw_wdata", snap_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(mk_inst(3'b010, 7'h03), 1'b1, 2'd1, 1'b1, 1'b0, 32'h404, 32'h0, 5'd13);
    run_mem(1, 32'hCAFE_F00D);
    check_eq("lw_addr", snap_addr, 32'h404);
    check_eq("lw_data", rdata_wb, 32'hCAFE_F00D);
    check_eq("b2b_hs", hs_cnt - hs0, 32'd2);
    check_eq("b2b_store_once", st_cnt - st0, 32'd1);

    // Ack with no request is ignored
    @(negedge clk);
    drive(32'h00000033, 1'b1, 2'd0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
    hs0 = hs_cnt;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_eq("stray_ack_hs", hs_cnt - hs0, 32'd0);
    check_eq("stray_ack_rdata", rdata_wb, 32'd0);
    check_eq("stray_ack_alu", alu_res_wb, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
